// File: rtl/if_fetch_unit_pkg.sv
// Shared encodings for the instruction-fetch stage: stall bit positions,
// control-level constants and the fetch state machine encoding.
package if_fetch_unit_pkg;

  localparam int STALL_IF = 1;

  localparam logic JUMP       = 1'b1;
  localparam logic NO_STALL   = 1'b0;
  localparam logic RST_ENABLE = 1'b1;

  localparam int          INST_W = 32;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] ZERO32 = 32'h0;

  typedef enum logic [2:0] {
    S_CHECK = 3'd0,
    S_B0    = 3'd1,
    S_B1    = 3'd2,
    S_B2    = 3'd3,
    S_B3    = 3'd4,
    S_DONE  = 3'd5
  } fetch_state_e;

  function automatic logic is_byte_state(input fetch_state_e s);
    return (s == S_B0) || (s == S_B1) || (s == S_B2) || (s == S_B3);
  endfunction

  // Byte offset within the word that the current byte state requests.
  function automatic logic [1:0] byte_sel(input fetch_state_e s);
    logic [1:0] k;
    case (s)
      S_B1:    k = 2'd1;
      S_B2:    k = 2'd2;
      S_B3:    k = 2'd3;
      default: k = 2'd0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: control from the pipeline, byte port to the memory
// arbiter and the IF/ID outputs. master = fetch unit, slave = its environment.
interface if_fetch_unit_if #(
  parameter int STALL_W = 6
);
  logic               rdy_in;
  logic [STALL_W-1:0] stall_in;
  logic               pcJump_in;
  logic [31:0]        pcTarget_in;
  logic               memReq_out;
  logic [31:0]        memAddr_out;
  logic               memValid_in;
  logic [7:0]         memData_in;
  logic               stallReq_out;
  logic               instE_out;
  logic [31:0]        pc_out;
  logic [31:0]        inst_out;

  modport master (
    input  rdy_in, stall_in, pcJump_in, pcTarget_in, memValid_in, memData_in,
    output memReq_out, memAddr_out, stallReq_out, instE_out, pc_out, inst_out
  );

  modport slave (
    output rdy_in, stall_in, pcJump_in, pcTarget_in, memValid_in, memData_in,
    input  memReq_out, memAddr_out, stallReq_out, instE_out, pc_out, inst_out
  );
endinterface

// File: rtl/if_fetch_unit_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Combinational lookup, synchronous fill; only the valid bits are reset.
module if_fetch_unit_icache #(
  parameter  int ICACHE_IDX_W = 7,
  parameter  int ADDR_BITS    = 17,
  localparam int TAG_W        = ADDR_BITS - ICACHE_IDX_W - 2,
  localparam int LINES        = 1 << ICACHE_IDX_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ICACHE_IDX_W-1:0] idx_i,
  input  logic [TAG_W-1:0]        tag_i,
  output logic                    hit_o,
  output logic [31:0]             rd_data_o,
  input  logic                    we_i,
  input  logic [31:0]             wr_data_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  assign hit_o     = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
  assign rd_data_o = data_q[idx_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, looks up the icache and on a miss
// assembles the word from four byte reads before handing it to IF/ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ADDR_BITS    = 17,
  parameter int          ICACHE_IDX_W = 7,
  parameter int          STALL_W      = 6
) (
  input  logic            clk_in,
  input  logic            rst_in,
  if_fetch_unit_if.master bus
);

  localparam int TAG_W     = ADDR_BITS - ICACHE_IDX_W - 2;
  localparam int STALL_BIT = (STALL_IF < STALL_W) ? STALL_IF : 0;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  word_q, word_d;
  logic [23:0]  buf_q, buf_d;

  logic                    cache_hit;
  logic [31:0]             cache_rdata;
  logic                    cache_we;
  logic [ICACHE_IDX_W-1:0] cache_idx;
  logic [TAG_W-1:0]        cache_tag;
  logic                    done;

  assign cache_idx = pc_q[ICACHE_IDX_W+1:2];
  assign cache_tag = pc_q[ADDR_BITS-1:ICACHE_IDX_W+2];

  if_fetch_unit_icache #(
    .ICACHE_IDX_W (ICACHE_IDX_W),
    .ADDR_BITS    (ADDR_BITS)
  ) u_icache (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .idx_i     (cache_idx),
    .tag_i     (cache_tag),
    .hit_o     (cache_hit),
    .rd_data_o (cache_rdata),
    .we_i      (cache_we),
    .wr_data_i ({bus.memData_in, buf_q})
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in == RST_ENABLE) begin
      state_q <= S_CHECK;
      pc_q    <= RESET_PC;
      word_q  <= ZERO32;
      buf_q   <= '0;
    end else if (bus.rdy_in) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      word_q  <= word_d;
      buf_q   <= buf_d;
    end
  end

  // Redirect outranks everything, including a byte returning this cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    word_d   = word_q;
    buf_d    = buf_q;
    cache_we = 1'b0;
    if (bus.pcJump_in == JUMP) begin
      pc_d    = bus.pcTarget_in & ~32'h3;
      state_d = S_CHECK;
    end else begin
      case (state_q)
        S_CHECK: begin
          if (cache_hit) begin
            word_d  = cache_rdata;
            state_d = S_DONE;
          end else begin
            state_d = S_B0;
          end
        end
        S_B0: if (bus.memValid_in) begin
          buf_d[7:0] = bus.memData_in;
          state_d    = S_B1;
        end
        S_B1: if (bus.memValid_in) begin
          buf_d[15:8] = bus.memData_in;
          state_d     = S_B2;
        end
        S_B2: if (bus.memValid_in) begin
          buf_d[23:16] = bus.memData_in;
          state_d      = S_B3;
        end
        S_B3: if (bus.memValid_in) begin
          word_d   = {bus.memData_in, buf_q};
          cache_we = bus.rdy_in;
          state_d  = S_DONE;
        end
        S_DONE: if (bus.stall_in[STALL_BIT] == NO_STALL) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_CHECK;
        end
        default: state_d = S_CHECK;
      endcase
    end
  end

  assign done             = (state_q == S_DONE);
  assign bus.memReq_out   = is_byte_state(state_q);
  assign bus.memAddr_out  = bus.memReq_out ? (pc_q + {30'b0, byte_sel(state_q)}) : ZERO32;
  assign bus.instE_out    = done;
  assign bus.stallReq_out = ~done;
  assign bus.pc_out       = done ? pc_q : ZERO32;
  assign bus.inst_out     = done ? word_q : ZERO32;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized fetch/redirect
// traffic checked against a PC/cache/memory reference model.
module tb_if_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_unit_if #(.STALL_W(6)) bus ();

  if_fetch_unit #(
    .RESET_PC     (32'h0),
    .ADDR_BITS    (17),
    .ICACHE_IDX_W (7),
    .STALL_W      (6)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] pc_m;
  logic [7:0]  m_tag  [int];
  logic [31:0] m_data [int];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] b;
    case (a)
      32'd0:   b = 8'h13;
      32'd1:   b = 8'h05;
      32'd2:   b = 8'h50;
      32'd3:   b = 8'h00;
      default: b = 8'(a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] p);
    return {mem_byte(p + 32'd3), mem_byte(p + 32'd2), mem_byte(p + 32'd1), mem_byte(p)};
  endfunction

  function automatic int idx_of(input logic [31:0] p);
    return int'(p[8:2]);
  endfunction

  function automatic bit model_hit(input logic [31:0] p);
    return m_tag.exists(idx_of(p)) && (m_tag[idx_of(p)] == p[16:9]);
  endfunction

  task automatic set_stall(input logic b);
    logic [5:0] s;
    s = 6'($urandom);
    s[1] = b;
    bus.stall_in = s;
  endtask

  task automatic apply_redirect(input logic [31:0] tgt);
    pc_m = tgt & ~32'h3;
    chk("redir_inste", 32'(bus.instE_out), 32'd0);
    chk("redir_req",   32'(bus.memReq_out), 32'd0);
    chk("redir_pc",    bus.pc_out, 32'd0);
    chk("redir_inst",  bus.inst_out, 32'd0);
  endtask

  task automatic check_byte_req(input logic [31:0] addr);
    chk("byte_req",  32'(bus.memReq_out), 32'd1);
    chk("byte_addr", bus.memAddr_out, addr);
  endtask

  // Called with the DUT about to evaluate a fresh S_CHECK; returns in S_CHECK.
  // redir_at: -1 none, 0 during lookup, 1..4 with byte k=redir_at-1, 5 in done.
  task automatic run_fetch(input int lat_max, input int stall_n, input int redir_at,
                           input logic [31:0] tgt, input bit freeze_b1);
    logic [31:0] p;
    logic [31:0] exp_inst;
    bit          hit;
    p   = pc_m;
    hit = model_hit(p);
    chk("lookup_req",   32'(bus.memReq_out), 32'd0);
    chk("lookup_inste", 32'(bus.instE_out), 32'd0);
    chk("lookup_sreq",  32'(bus.stallReq_out), 32'd1);
    set_stall($urandom_range(0, 1) == 1);
    bus.memValid_in = 1'($urandom);
    if (redir_at == 0) begin
      bus.pcJump_in = 1'b1; bus.pcTarget_in = tgt;
      step();
      bus.pcJump_in = 1'b0; bus.memValid_in = 1'b0;
      apply_redirect(tgt);
      return;
    end
    step();
    bus.memValid_in = 1'b0;
    if (hit) begin
      exp_inst = m_data[idx_of(p)];
    end else begin
      exp_inst = mem_word(p);
      for (int k = 0; k < 4; k++) begin
        int w;
        w = $urandom_range(0, lat_max);
        check_byte_req(p + 32'(k));
        if (freeze_b1 && k == 1) begin
          for (int i = 0; i < 4; i++) begin
            bus.rdy_in = 1'b0; bus.memValid_in = 1'(i); bus.memData_in = 8'($urandom);
            step();
            check_byte_req(p + 32'd1);
          end
          bus.rdy_in = 1'b1; bus.memValid_in = 1'b0;
        end
        for (int i = 0; i < w; i++) begin
          bus.rdy_in = ($urandom_range(0, 3) != 0);
          bus.memValid_in = bus.rdy_in ? 1'b0 : 1'($urandom);
          bus.memData_in = 8'($urandom);
          step();
          bus.rdy_in = 1'b1; bus.memValid_in = 1'b0;
          check_byte_req(p + 32'(k));
        end
        bus.memValid_in = 1'b1; bus.memData_in = mem_byte(p + 32'(k));
        if (redir_at == k + 1) begin
          bus.pcJump_in = 1'b1; bus.pcTarget_in = tgt;
          step();
          bus.pcJump_in = 1'b0; bus.memValid_in = 1'b0;
          apply_redirect(tgt);
          return;
        end
        step();
        bus.memValid_in = 1'b0;
      end
      m_tag[idx_of(p)]  = p[16:9];
      m_data[idx_of(p)] = exp_inst;
    end
    chk("done_inste", 32'(bus.instE_out), 32'd1);
    chk("done_pc",    bus.pc_out, p);
    chk("done_inst",  bus.inst_out, exp_inst);
    chk("done_sreq",  32'(bus.stallReq_out), 32'd0);
    chk("done_req",   32'(bus.memReq_out), 32'd0);
    for (int s = 0; s < stall_n; s++) begin
      set_stall(1'b1);
      bus.memValid_in = 1'($urandom);
      step();
      bus.memValid_in = 1'b0;
      chk("hold_inste", 32'(bus.instE_out), 32'd1);
      chk("hold_pc",    bus.pc_out, p);
      chk("hold_inst",  bus.inst_out, exp_inst);
      chk("hold_req",   32'(bus.memReq_out), 32'd0);
    end
    if (redir_at == 5) begin
      set_stall($urandom_range(0, 1) == 1);
      bus.pcJump_in = 1'b1; bus.pcTarget_in = tgt;
      step();
      bus.pcJump_in = 1'b0;
      apply_redirect(tgt);
      return;
    end
    set_stall(1'b0);
    step();
    pc_m = p + 32'd4;
    chk("handoff_inste", 32'(bus.instE_out), 32'd0);
    chk("handoff_pc",    bus.pc_out, 32'd0);
    chk("handoff_inst",  bus.inst_out, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rdy_in      = 1'b1;
    bus.stall_in    = '0;
    bus.pcJump_in   = 1'b0;
    bus.pcTarget_in = '0;
    bus.memValid_in = 1'b0;
    bus.memData_in  = '0;
    pc_m = 32'h0;
    step();
    step();
    chk("rst_inste", 32'(bus.instE_out), 32'd0);
    chk("rst_pc",    bus.pc_out, 32'd0);
    chk("rst_inst",  bus.inst_out, 32'd0);
    chk("rst_req",   32'(bus.memReq_out), 32'd0);
    chk("rst_addr",  bus.memAddr_out, 32'd0);
    chk("rst_sreq",  32'(bus.stallReq_out), 32'd1);
    rst = 1'b0;

    run_fetch(0, 3, -1, 32'h0, 1'b0);
    chk("first_word_model", m_data[0], 32'h00500513);
    run_fetch(0, 0, 3, 32'h106, 1'b0);
    chk("redir_target_pc", pc_m, 32'h104);
    run_fetch(2, 0, 5, 32'h0, 1'b0);
    run_fetch(0, 0, -1, 32'h0, 1'b0);
    run_fetch(0, 1, -1, 32'h0, 1'b1);
    run_fetch(0, 0, 5, 32'hFFFF_FFFF, 1'b0);
    run_fetch(1, 0, -1, 32'h0, 1'b0);
    chk("wrap_pc", pc_m, 32'h0);
    run_fetch(0, 0, -1, 32'h0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int          ra;
      logic [31:0] tgt;
      ra  = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 5)) : -1;
      tgt = 32'($urandom_range(0, 1023));
      run_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), ra, tgt, 1'b0);
    end

    run_fetch(0, 0, 0, 32'h2000, 1'b0);
    step();
    check_byte_req(32'h2000);
    bus.memValid_in = 1'b1; bus.memData_in = mem_byte(32'h2000);
    step();
    bus.memValid_in = 1'b0;
    check_byte_req(32'h2001);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req",   32'(bus.memReq_out), 32'd0);
    chk("arst_addr",  bus.memAddr_out, 32'd0);
    chk("arst_inste", 32'(bus.instE_out), 32'd0);
    chk("arst_sreq",  32'(bus.stallReq_out), 32'd1);
    chk("arst_pc",    bus.pc_out, 32'd0);
    chk("arst_inst",  bus.inst_out, 32'd0);
    step();
    rst = 1'b0;
    m_tag.delete();
    m_data.delete();
    pc_m = 32'h0;
    run_fetch(0, 0, -1, 32'h0, 1'b0);
    run_fetch(1, 1, -1, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage. It is the producer side of the IF/ID pipeline register and drives pc/inst/instE into it. It owns the PC and reads 32-bit instructions byte-by-byte from the byte-wide memory arbiter, with a small direct-mapped instruction cache in front. Redirects arrive from EX via pcJump_in/pcTarget_in, and stall requests go to the stall controller.

Parameters:
RESET_PC, 32'h0, PC value after reset
ADDR_BITS, 17, significant memory address bits used for cache tags
ICACHE_IDX_W, 7, log2 of cache lines (one 32-bit word per line)
STALL_W, 6, width of stall vector; bit 1 = IF stage

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous reset, active-high
rdy_in  in  1  global ready; when 0, all state frozen
stall_in  in  STALL_W  stall vector; stall_in[1]=1 means IF/ID will not latch this cycle
pcJump_in  in  1  redirect request (jump/taken branch)
pcTarget_in  in  32  redirect target
memReq_out  out  1  byte read request to arbiter
memAddr_out  out  32  byte address of request
memValid_in  in  1  requested byte returned this cycle
memData_in  in  8  returned byte
stallReq_out  out  1  fetch not ready; request pipeline stall
instE_out  out  1  pc_out/inst_out hold a valid instruction
pc_out  out  32  instruction address, 0 when instE_out=0
inst_out  out  32  instruction word, 0 (bubble) when instE_out=0

Behaviour:
- Reset (async, rst_in=1): pc=RESET_PC; state=S_CHECK; all cache valid bits=0; byte buffer=0; memReq_out=0; memAddr_out=0; instE_out=0; pc_out=0; inst_out=0; stallReq_out=1.
- rdy_in=0: no register or cache updates; memValid_in ignored; outputs hold.
- States: S_CHECK, S_B0, S_B1, S_B2, S_B3, S_DONE.
- S_CHECK: combinational cache lookup. index=pc[ICACHE_IDX_W+1:2]; tag=pc[ADDR_BITS-1:ICACHE_IDX_W+2].
  - Hit: register the word and go to S_DONE. instE_out=1 from the next cycle.
  - Miss: go to S_B0.
- S_Bk (k=0..3): memReq_out=1 and memAddr_out=pc+k, held until memValid_in=1. On valid, buffer byte k=memData_in and advance.
  - S_B3 on valid: instruction={b3,b2,b1,b0} (little-endian); write cache line (valid, tag, data); go to S_DONE.
- Miss latency is 1+(byte wait cycles); the minimum is 5 cycles from S_CHECK to instE_out=1.
- memReq_out=0 outside S_Bk. memValid_in outside S_Bk is ignored.
- S_DONE: instE_out=1, pc_out=pc, inst_out=word.
  - stall_in[1]=0: handoff accepted at this edge; pc<=pc+4; go to S_CHECK; instE_out=0 next cycle.
  - stall_in[1]=1: hold all outputs unchanged.
- stallReq_out = ~instE_out (registered state, no combinational path from inputs).
- Redirect (pcJump_in=1, rdy_in=1) has priority over everything in any state:
  - pc<=(pcTarget_in & ~32'h3); state<=S_CHECK; instE_out<=0; pc_out/inst_out<=0.
  - Partial bytes are discarded. A memValid_in in the same cycle is ignored and causes no cache write.
- PC is a 32-bit wrap-around add; 32'hFFFFFFFC+4 becomes 0.
- Cache contents are only cleared by reset; there is no invalidate (no self-modifying code support).

Decomposition:
- Shared defines package: stall bit indices, Jump/NoStall/rstEnable encodings, ZERO32, instruction/address ranges, and the fetch state encoding.
- One sub-module, if_icache:
  - Parameters ICACHE_IDX_W and ADDR_BITS.
  - Combinational read (hit, data).
  - Synchronous write port.
  - Valid bits reset asynchronously.
  - Tag/data arrays are not reset.

Test Plan:
- Reset then release with rdy_in=1, stall_in=0, memory returns 13,05,50,00 at addr 0..3 (1-cycle valid each) -> memAddr_out sequence 0,1,2,3; then instE_out=1, pc_out=0, inst_out=32'h00500513; stallReq_out=0 that cycle.
- Hold instruction in S_DONE with stall_in[1]=1 for 3 cycles -> outputs stable, memReq_out=0. Release -> next fetch at memAddr_out=4.
- Redirect during S_B2 with pcJump_in=1, pcTarget_in=32'h106, memValid_in=1 that cycle -> no cache write, instE_out=0. Next requests start at 32'h104.
- Loop back to pc=0 after the first fetch -> hit, no memReq_out. instE_out=1 one cycle after S_CHECK with inst_out=32'h00500513.
- rdy_in=0 for 4 cycles mid-S_B1 with memValid_in toggling -> state and buffer unchanged. Resume yields the correct word.
- Assert rst_in asynchronously mid-fetch -> outputs zero immediately (before the next edge); the first request after release is at RESET_PC; the prior line reads as a miss.
